// File: rtl/dds_nco.sv
// Phase-accumulating NCO front end for a registered sine ROM.
// Drives the ROM address, scales the returned word by amp and emits one sample per step.
module dds_nco #(
    parameter int PHASE_WIDTH = 30,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   clear,
    input  logic [PHASE_WIDTH-1:0] ftw,
    input  logic [PHASE_WIDTH-1:0] phase_off,
    input  logic [DATA_WIDTH-1:0]  amp,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid,
    output logic                   wrap
);

    localparam int PW = PHASE_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_sum;
    logic [PW-1:0]   phase_nxt;
    logic            carry;
    logic            step;
    logic            s1;
    logic            s2;
    logic            c1;
    logic            c2;
    logic [2*DW:0]   rom_ext;
    logic [2*DW:0]   amp_ext;
    logic [2*DW:0]   prod;
    logic            prod_unused;

    assign step = tick & en & ~clear;
    assign phase_sum = phase + phase_off;
    assign {carry, phase_nxt} = {1'b0, phase} + {1'b0, ftw};

    // Both operands widened to the full product width so the
    // truncated multiply equals the exact signed product.
    assign rom_ext = {{(DW+1){rom_data[DW-1]}}, rom_data};
    assign amp_ext = {{(DW+1){1'b0}}, amp};
    assign prod = rom_ext * amp_ext;

    assign prod_unused = ^{prod[2*DW], prod[DW-1:0], phase_sum[PW-AW-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            rom_addr <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (step) begin
            phase    <= phase_nxt;
            rom_addr <= phase_sum[PW-1 -: AW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            c1           <= 1'b0;
            c2           <= 1'b0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            sample       <= '0;
        end else begin
            s1           <= step;
            c1           <= step & carry;
            s2           <= s1;
            c2           <= c1;
            sample_valid <= s2;
            wrap         <= s2 & c2;
            if (s2) begin
                sample <= prod[2*DW-1:DW];
            end
        end
    end

endmodule

// File: tb/tb_dds_nco.sv
// Bench for dds_nco: sine ROM model, phase/sample reference model
// compared every cycle, plus directed literal expectations.
module tb_dds_nco;

    localparam int  PW   = 30;
    localparam int  AW   = 8;
    localparam int  DW   = 16;
    localparam longint PMOD = 64'd1 << PW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          en;
    logic          tick;
    logic          clear;
    logic [PW-1:0] ftw;
    logic [PW-1:0] phase_off;
    logic [DW-1:0] amp;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          wrap;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] rom [256];

    always #5 clk = ~clk;

    dds_nco #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .tick(tick),
        .clear(clear),
        .ftw(ftw),
        .phase_off(phase_off),
        .amp(amp),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .sample(sample),
        .sample_valid(sample_valid),
        .wrap(wrap)
    );

    initial begin
        for (int a = 0; a < 256; a++) begin
            real r;
            int v;
            r = 32767.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
            v = int'(r);
            rom[a] = v[15:0];
        end
        rom[64]  = 16'h7FFF;
        rom[192] = 16'h8001;
    end

    // Sine ROM with one-cycle registered read
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        longint        due;
    } ent_t;

    ent_t          q[$];
    ent_t          e;
    longint        cyc = 0;
    longint        mph = 0;
    longint        sum;
    longint        nxt;
    longint        p;
    logic [AW-1:0] maddr = '0;
    logic          mvalid = 1'b0;
    logic          mwrap = 1'b0;
    logic [DW-1:0] msample = '0;

    // Reference model: each step queues its address and carry, the
    // sample is produced from ROM*amp two edges later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            mph     = 0;
            maddr   = '0;
            mvalid  = 1'b0;
            mwrap   = 1'b0;
            msample = '0;
        end else begin
            mvalid = 1'b0;
            mwrap  = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                mvalid  = 1'b1;
                mwrap   = e.w;
                p       = longint'($signed(rom[e.a])) * longint'(amp);
                msample = 16'(p >>> 16);
            end
            if (clear) begin
                mph = 0;
            end else if (tick && en) begin
                sum   = (mph + longint'(phase_off)) % PMOD;
                maddr = AW'(sum >> (PW - AW));
                nxt   = mph + longint'(ftw);
                q.push_back('{maddr, nxt >= PMOD, cyc + 2});
                mph   = nxt % PMOD;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("m_rom_addr", 64'(rom_addr), 64'(maddr));
        chk("m_valid", 64'(sample_valid), 64'(mvalid));
        chk("m_wrap", 64'(wrap), 64'(mwrap));
        chk("m_sample", 64'(sample), 64'(msample));
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] held;

    initial begin
        en = 1'b1;
        tick = 1'b1;
        clear = 1'b0;
        ftw = '0;
        phase_off = '0;
        amp = 16'hFFFF;
        #1 reset_n = 1'b0;
        repeat (3) cyc1();
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);

        reset_n = 1'b1;
        cyc1();
        chk("rst_lat0", 64'(sample_valid), 64'd0);
        cyc1();
        chk("rst_lat1", 64'(sample_valid), 64'd0);
        cyc1();
        chk("rst_lat2", 64'(sample_valid), 64'd1);
        tick = 1'b0;
        repeat (4) cyc1();

        // Offset
        phase_off = 30'd1 << 28;
        amp = 16'h8000;
        tick = 1'b1;
        cyc1();
        chk("off_addr", 64'(rom_addr), 64'd64);
        tick = 1'b0;
        cyc1();
        cyc1();
        chk("off_valid", 64'(sample_valid), 64'd1);
        chk("off_sample", 64'(sample), 64'h3FFF);
        cyc1();
        chk("off_valid_end", 64'(sample_valid), 64'd0);

        // Full sweep
        phase_off = '0;
        ftw = 30'd1 << 22;
        amp = 16'hFFFF;
        tick = 1'b1;
        for (int i = 0; i <= 258; i++) begin
            cyc1();
            if (i == 256) tick = 1'b0;
            if (i <= 256) chk("sw_addr", 64'(rom_addr), 64'(i % 256));
            if (i >= 2) begin
                chk("sw_wrap", 64'(wrap), 64'((i - 2) == 255));
                if (i - 2 == 64) chk("sw_s64", 64'(sample), 64'h7FFE);
                if (i - 2 == 192) chk("sw_s192", 64'(sample), 64'h8001);
            end
        end
        cyc1();

        // Clear priority
        ftw = 30'd1 << 24;
        tick = 1'b1;
        cyc1();
        cyc1();
        held = rom_addr;
        clear = 1'b1;
        cyc1();
        chk("clr_inflight_a", 64'(sample_valid), 64'd1);
        chk("clr_addr_hold", 64'(rom_addr), 64'(held));
        clear = 1'b0;
        cyc1();
        chk("clr_addr0", 64'(rom_addr), 64'd0);
        chk("clr_inflight_b", 64'(sample_valid), 64'd1);
        tick = 1'b0;
        cyc1();
        chk("clr_nosample", 64'(sample_valid), 64'd0);
        cyc1();
        chk("clr_next", 64'(sample_valid), 64'd1);
        cyc1();

        // Enable gating
        en = 1'b0;
        held = rom_addr;
        for (int j = 0; j < 16; j++) begin
            tick = (j % 4 == 0);
            cyc1();
            chk("en_novalid", 64'(sample_valid), 64'd0);
        end
        tick = 1'b0;
        chk("en_hold", 64'(rom_addr), 64'(held));
        en = 1'b1;
        tick = 1'b1;
        cyc1();
        chk("en_resume", 64'(rom_addr), 64'd4);
        tick = 1'b0;
        repeat (3) cyc1();

        // Sparse ticks, amp drops before the third sample's scale stage
        ftw = 30'd1 << 23;
        amp = 16'hFFFF;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 5; c++) begin
                tick = (c == 0);
                if (t == 2 && c == 2) amp = 16'h0000;
                cyc1();
                if (c == 2) chk("sp_valid", 64'(sample_valid), 64'd1);
                if (t == 2 && c == 2) chk("sp_amp0", 64'(sample), 64'h0000);
            end
        end
        tick = 1'b0;

        // Reset mid-operation flushes the pipeline
        amp = 16'hFFFF;
        tick = 1'b1;
        cyc1();
        cyc1();
        reset_n = 1'b0;
        tick = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(sample_valid), 64'd0);
        chk("mid_rst_addr", 64'(rom_addr), 64'd0);
        cyc1();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc1();
            chk("mid_rst_flush", 64'(sample_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
